// File: rtl/result_bcd_converter_if.sv
// Handshake and data bundle between the arithmetic unit and the BCD converter.
interface result_bcd_converter_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  signed_mode;
    logic                  busy;
    logic                  valid;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  neg;
    logic                  ovf;

    modport master (
        output start, bin_in, signed_mode,
        input  busy, valid, bcd_out, neg, ovf
    );

    modport slave (
        input  start, bin_in, signed_mode,
        output busy, valid, bcd_out, neg, ovf
    );
endinterface

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: binary (optionally two's complement)
// result to packed BCD, one bit per cycle, with sign and 4-digit overflow flag.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CONV  | WIDTH add-3/shift iterations over the captured magnitude
// DONE  | one-cycle valid pulse, then back to IDLE
module result_bcd_converter #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    result_bcd_converter_if.slave        bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    mag_q,     mag_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic                neg_pend_q;
    logic                busy_q, valid_q, neg_q, ovf_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [BCD_W-1:0]    adj;
    logic                ovf_d;

    // One double-dabble step: correct digits >= 5, then shift in the next magnitude bit.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        scratch_d = {adj[BCD_W-2:0], mag_q[WIDTH-1]};
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
    end

    // Overflow means any digit above the thousands place is non-zero.
    always_comb begin
        ovf_d = 1'b0;
        for (int i = 4; i < DIGITS; i++) begin
            if (scratch_d[4*i +: 4] != 4'd0)
                ovf_d = 1'b1;
        end
    end

    // Control FSM with registered outputs; the negated value of the most
    // negative input still fits WIDTH bits as an unsigned magnitude.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            scratch_q  <= '0;
            neg_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.signed_mode && bus.bin_in[WIDTH-1]) begin
                            mag_q      <= -bus.bin_in;
                            neg_pend_q <= 1'b1;
                        end else begin
                            mag_q      <= bus.bin_in;
                            neg_pend_q <= 1'b0;
                        end
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    scratch_q <= scratch_d;
                    mag_q     <= mag_d;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        bcd_q   <= scratch_d;
                        neg_q   <= neg_pend_q;
                        ovf_q   <= ovf_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.valid   = valid_q;
    assign bus.bcd_out = bcd_q;
    assign bus.neg     = neg_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 SHALL have parameter WIDTH, default 14, binary operand width matching the calculator datapath.
REQ-002 SHALL have parameter DIGITS, default 5, number of BCD output digits (covers 0..16383).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-006 SHALL have port bin_in  input  WIDTH  binary result from the arithmetic unit.
REQ-007 SHALL have port signed_mode  input  1  1 = treat bin_in as two's complement.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port valid  output  1  one-cycle pulse, outputs updated.
REQ-010 SHALL have port bcd_out  output  4*DIGITS  packed BCD, digit 0 in bits [3:0].
REQ-011 SHALL have port neg  output  1  sign of the converted value.
REQ-012 SHALL have port ovf  output  1  magnitude > 9999, i.e. exceeds a 4-digit display.

Function
REQ-013 SHALL implement an FSM with states IDLE, CONV, DONE.
REQ-014 In IDLE with start=1, SHALL capture bin_in and signed_mode, clear the BCD scratch register, zero the shift counter, and go to CONV.
REQ-015 Capture SHALL store the magnitude: if signed_mode=1 and bin_in[WIDTH-1]=1, magnitude = two's-complement negation of bin_in, neg_pending=1; otherwise magnitude = bin_in, neg_pending=0.
REQ-016 Magnitude of 14'h2000 in signed mode SHALL be 8192, with WIDTH bits sufficient and no extra bit needed.
REQ-017 In CONV, each cycle SHALL add 3 to every scratch BCD digit >= 5, then shift {scratch, magnitude} left by one bit.
REQ-018 CONV SHALL last exactly WIDTH cycles, counted by the shift counter, then go to DONE.
REQ-019 On the CONV->DONE edge, SHALL load bcd_out, neg and ovf from the final scratch and sign.
REQ-020 valid SHALL be high only in DONE, for exactly one cycle; DONE SHALL then go to IDLE unconditionally.
REQ-021 Latency: start sampled at edge N -> valid high in the cycle following edge N+WIDTH (14 cycles for default).
REQ-022 start while busy=1 SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-023 start in the DONE cycle SHALL be ignored; back-to-back conversions SHALL accept a new start no earlier than the first IDLE cycle.
REQ-024 bcd_out, neg and ovf SHALL hold their last values until the next DONE entry.
REQ-025 bin_in and signed_mode changes after capture SHALL NOT affect the result.
REQ-026 Every output digit SHALL be in range 0..9; unsigned 16383 SHALL give digits 1,6,3,8,3.
REQ-027 neg SHALL be 0 when signed_mode=0 regardless of bin_in[WIDTH-1].

Reset
REQ-028 rst_n low SHALL force, asynchronously: state IDLE, busy 0, valid 0, bcd_out 0, neg 0, ovf 0, counter and scratch 0.
REQ-029 Reset asserted mid-CONV SHALL abort the conversion, with no valid pulse and outputs zero; after release the block SHALL accept start normally.
REQ-030 After rst_n deasserts, the first start SHALL be sampled no earlier than the first rising edge with rst_n high.

Verification
REQ-031 unsigned bin_in=0, start -> valid after 14 cycles, bcd_out=0x00000, neg=0, ovf=0.
REQ-032 unsigned bin_in=9999 -> bcd_out=0x09999, ovf=0; then bin_in=10000 -> bcd_out=0x10000, ovf=1.
REQ-033 unsigned bin_in=14'h3FFF -> bcd_out=0x16383, neg=0, ovf=1; signed bin_in=14'h3FFF -> bcd_out=0x00001, neg=1, ovf=0.
REQ-034 signed bin_in=14'h2000 -> bcd_out=0x08192, neg=1, ovf=0; signed bin_in=14'h1FFF -> bcd_out=0x08191, neg=0.
REQ-035 start with 123, then start with 456 pulsed 3 cycles later -> single valid, bcd_out=0x00123; 456 converts only if start is re-asserted in IDLE.
REQ-036 start with 4321, rst_n low at cycle 7 for 2 cycles -> no valid, all outputs 0; after release, start with 55 -> bcd_out=0x00055 after 14 cycles.
